// File: rtl/flop_pkg.sv
// flop_pkg: shared defaults and parameter validation for the flop_dff delay line.
// Contents:
//   FLOP_DEFAULT_WIDTH / FLOP_DEFAULT_DEPTH - default data width and stage count
//   flop_params_ok()                        - true when WIDTH and DEPTH are both legal (>= 1)
package flop_pkg;
   localparam int FLOP_DEFAULT_WIDTH = 1;
   localparam int FLOP_DEFAULT_DEPTH = 1;
   function automatic bit flop_params_ok(input int width, input int depth);
      return (width >= 1) && (depth >= 1);
   endfunction
endpackage

// File: rtl/flop_stage.sv
// flop_stage: one WIDTH-bit register stage with async reset, hold enable and optional sync clear.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, loads RESET_VALUE
//   clr   - synchronous clear to RESET_VALUE, only when FLOP_SYNC_CLR_EN is defined
//   en    - capture enable; 0 holds the stored value
//   d     - WIDTH-bit data in
//   q     - WIDTH-bit registered data out
module flop_stage
   import flop_pkg::*;
#(
   parameter int               WIDTH       = FLOP_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
`ifdef FLOP_SYNC_CLR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;
   always_comb begin
`ifdef FLOP_SYNC_CLR_EN
      data_d = clr ? RESET_VALUE : (en ? d : data_q);
`else
      data_d = en ? d : data_q;
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) data_q <= RESET_VALUE;
      else       data_q <= data_d;
   end
   assign q = data_q;
endmodule

// File: rtl/flop_dff.sv
// flop_dff: parameterizable D flip-flop bank / fixed-latency delay line of DEPTH stages.
// Optional feature: define FLOP_SYNC_CLR_EN to add a synchronous clear input.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, every stage loads RESET_VALUE
//   clr   - synchronous clear (FLOP_SYNC_CLR_EN only), beats en, loses to reset
//   en    - shift enable; 0 stalls the whole chain
//   d     - WIDTH-bit data in
//   q     - WIDTH-bit data out, the last stage
module flop_dff
   import flop_pkg::*;
#(
   parameter int               WIDTH       = FLOP_DEFAULT_WIDTH,
   parameter int               DEPTH       = FLOP_DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
`ifdef FLOP_SYNC_CLR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   if (!flop_params_ok(WIDTH, DEPTH)) begin : g_bad_params
      $error("flop_dff: WIDTH and DEPTH must both be at least 1");
   end
   logic [WIDTH-1:0] stage_q [DEPTH];
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] stage_in;
      if (i == 0) begin : g_head
         assign stage_in = d;
      end else begin : g_link
         assign stage_in = stage_q[i-1];
      end
      flop_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
`ifdef FLOP_SYNC_CLR_EN
         .clr   (clr),
`endif
         .en    (en),
         .d     (stage_in),
         .q     (stage_q[i])
      );
   end
   assign q = stage_q[DEPTH-1];
endmodule

// File: tb/tb_flop_dff.sv
// tb_flop_dff: directed self-checking bench for flop_dff (1x1 flop and 8-bit 3-deep line).
module tb_flop_dff;
   localparam int         DB = 3;
   localparam logic [7:0] RV = 8'hA5;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en_b = 1'b1;
   logic       d_a = 1'b0;
   logic [7:0] d_b = 8'h00;
   logic       q_a;
   logic [7:0] q_b;
`ifdef FLOP_SYNC_CLR_EN
   logic       clr_b = 1'b0;
`endif
   int  checks = 0;
   int  errors = 0;
   bit  started = 1'b0;
   bit  model_ok = 1'b0;
   time last_pos = 0;
   logic       m_a [$];
   logic [7:0] m_b [$];

   flop_dff u_a (
      .clk   (clk),
      .reset (reset),
`ifdef FLOP_SYNC_CLR_EN
      .clr   (1'b0),
`endif
      .en    (1'b1),
      .d     (d_a),
      .q     (q_a)
   );

   flop_dff #(.WIDTH(8), .DEPTH(DB), .RESET_VALUE(RV)) u_b (
      .clk   (clk),
      .reset (reset),
`ifdef FLOP_SYNC_CLR_EN
      .clr   (clr_b),
`endif
      .en    (en_b),
      .d     (d_b),
      .q     (q_b)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   // Model: each output is the value accepted DEPTH enabled edges ago; reset refills with RESET_VALUE.
   always @(posedge reset) begin
      m_a.delete();
      m_b.delete();
      m_a.push_back(1'b0);
      for (int i = 0; i < DB; i++) m_b.push_back(RV);
      model_ok = 1'b1;
   end

   always @(posedge clk) begin
      last_pos = $time;
      if (model_ok && !reset) begin
         m_a.push_front(d_a);
         void'(m_a.pop_back());
`ifdef FLOP_SYNC_CLR_EN
         if (clr_b) begin
            for (int i = 0; i < DB; i++) m_b[i] = RV;
         end else
`endif
         if (en_b) begin
            m_b.push_front(d_b);
            void'(m_b.pop_back());
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("model_q_a", {7'd0, q_a}, {7'd0, m_a[$]});
         check("model_q_b", q_b, m_b[$]);
      end
   end

   // Outputs may only move on a rising clock edge or while reset is asserted.
   always @(q_a or q_b) begin
      if (started) check("q_moves_only_at_edge_or_reset", {7'd0, (reset || $time == last_pos)}, 8'd1);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      started = 1'b1;
      #2 reset = 1'b1;
      #3;
      check("reset_q_a", {7'd0, q_a}, 8'd0);
      check("reset_q_b", q_b, RV);
      #10 reset = 1'b0;
      #7;
      for (int k = 0; k < 8; k++) begin
         d_a = k[0];
         #15;
      end
      check("toggle_last", {7'd0, q_a}, 8'd1);
      #3 reset = 1'b1;
      #1;
      check("async_q_a", {7'd0, q_a}, 8'd0);
      check("async_q_b", q_b, RV);
      d_a = 1'b1;
      d_b = 8'h11;
      #30;
      check("held_q_a", {7'd0, q_a}, 8'd0);
      check("held_q_b", q_b, RV);
      #9 reset = 1'b0;
      step();
      check("release_q_a", {7'd0, q_a}, 8'd1);
      check("pipe_e1", q_b, RV);
      d_b = 8'h22;
      step();
      check("pipe_e2", q_b, RV);
      d_b = 8'h33;
      step();
      check("pipe_e3", q_b, 8'h11);
      en_b = 1'b0;
      d_b = 8'h44;
      step();
      check("stall_1", q_b, 8'h11);
      step();
      check("stall_2", q_b, 8'h11);
      en_b = 1'b1;
      step();
      check("resume_22", q_b, 8'h22);
      step();
      check("resume_33", q_b, 8'h33);
      step();
      check("resume_44", q_b, 8'h44);
      d_b = 8'h55;
      step();
      d_b = 8'h66;
      step();
      reset = 1'b1;
      #1;
      check("midstream_reset", q_b, RV);
      d_b = 8'h77;
      #5 reset = 1'b0;
      step();
      check("after_rst_e1", q_b, RV);
      step();
      check("after_rst_e2", q_b, RV);
      step();
      check("after_rst_e3", q_b, 8'h77);
`ifdef FLOP_SYNC_CLR_EN
      d_b = 8'hFF;
      clr_b = 1'b1;
      step();
      check("clr_edge", q_b, RV);
      clr_b = 1'b0;
      step();
      check("clr_e1", q_b, RV);
      step();
      check("clr_e2", q_b, RV);
      step();
      check("clr_e3", q_b, 8'hFF);
`endif
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
